// File: rtl/gpia_input_byte_if.sv
// Register-bus bundle for the GPIA input byte: strobe/ack access port plus the interrupt line.
// Handshake: the master holds stb_i/we_i/adr_i/dat_i for each access cycle; the slave answers with ack_o
// exactly one cycle later, and dat_o is meaningful only while ack_o is high (no back-pressure).
interface gpia_input_byte_if;
  logic       stb_i;
  logic       we_i;
  logic [1:0] adr_i;
  logic [7:0] dat_i;
  logic [7:0] dat_o;
  logic       ack_o;
  logic       irq_o;

  modport slave (
    input  stb_i, we_i, adr_i, dat_i,
    output dat_o, ack_o, irq_o
  );

  modport master (
    output stb_i, we_i, adr_i, dat_i,
    input  dat_o, ack_o, irq_o
  );
endinterface

// File: rtl/gpia_input_byte.sv
// GPIA input byte: synchronizes eight pins, latches enabled rise/fall edges into sticky
// write-1-to-clear flags, and raises a level interrupt while any flag is set.
module gpia_input_byte #(
  parameter int         SYNC_STAGES   = 2,  // legal range 2..4
  parameter logic [7:0] RISE_EN_RESET = 8'h00,
  parameter logic [7:0] FALL_EN_RESET = 8'h00
) (
  input  logic                     clk_i,
  input  logic                     res_i,
  input  logic [7:0]               pins_i,
  gpia_input_byte_if.slave         bus
);

  localparam logic [2:0] PRIME_CNT = 3'(SYNC_STAGES + 1);

  localparam logic [1:0] ADR_PINS    = 2'd0;
  localparam logic [1:0] ADR_EVENTS  = 2'd1;
  localparam logic [1:0] ADR_RISE_EN = 2'd2;
  localparam logic [1:0] ADR_FALL_EN = 2'd3;

  logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
  logic [7:0] prev_q, prev_d;
  logic [7:0] events_q, events_d;
  logic [7:0] rise_en_q, rise_en_d;
  logic [7:0] fall_en_q, fall_en_d;
  logic [2:0] prime_q, prime_d;
  logic [7:0] dat_q, dat_d;
  logic       ack_q, ack_d;

  logic [7:0] s;
  logic       primed;
  logic [7:0] rise, fall, clr;
  logic       wr_acc, rd_acc;
  logic [7:0] rd_data;

  assign s      = sync_q[SYNC_STAGES-1];
  assign primed = (prime_q == PRIME_CNT);
  assign wr_acc = bus.stb_i & bus.we_i;
  assign rd_acc = bus.stb_i & ~bus.we_i;

  // Edges are suppressed until the chain and prev hold real pin samples, so pins
  // that are high out of reset never look like a rising edge.
  assign rise = s & ~prev_q & rise_en_q & {8{primed}};
  assign fall = ~s & prev_q & fall_en_q & {8{primed}};
  assign clr  = (wr_acc && bus.adr_i == ADR_EVENTS) ? bus.dat_i : 8'h00;

  always_comb begin
    rd_data = 8'h00;
    case (bus.adr_i)
      ADR_PINS:    rd_data = s;
      ADR_EVENTS:  rd_data = events_q;
      ADR_RISE_EN: rd_data = rise_en_q;
      ADR_FALL_EN: rd_data = fall_en_q;
      default:     rd_data = 8'h00;
    endcase
  end

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], pins_i};
    prev_d    = s;
    prime_d   = primed ? prime_q : prime_q + 3'd1;
    // A new edge wins over a simultaneous clear of the same bit.
    events_d  = (events_q & ~clr) | rise | fall;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    ack_d     = bus.stb_i;
    dat_d     = rd_acc ? rd_data : dat_q;
    if (wr_acc && bus.adr_i == ADR_RISE_EN) rise_en_d = bus.dat_i;
    if (wr_acc && bus.adr_i == ADR_FALL_EN) fall_en_d = bus.dat_i;
  end

  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) begin
      sync_q    <= '0;
      prev_q    <= 8'h00;
      events_q  <= 8'h00;
      rise_en_q <= RISE_EN_RESET;
      fall_en_q <= FALL_EN_RESET;
      prime_q   <= 3'd0;
      dat_q     <= 8'h00;
      ack_q     <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      events_q  <= events_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      prime_q   <= prime_d;
      dat_q     <= dat_d;
      ack_q     <= ack_d;
    end
  end

  assign bus.dat_o = dat_q;
  assign bus.ack_o = ack_q;
  assign bus.irq_o = |events_q;

endmodule

// File: doc/gpia_input_byte.md
Name: gpia_input_byte

Overview:
- 8-bit general-purpose input port; the read-side counterpart of the GPIA output byte.
- Synchronizes eight external pins and detects rising and falling edges per bit, with a separate enable for each direction.
- Latches detected edges into sticky event flags, and raises a level interrupt while any flag is set.
- A single-cycle strobe/ack register interface sits on the system bus next to the GPIA output byte.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops per pin; legal range 2..4.
- RISE_EN_RESET, 8'h00, reset value of the rising-edge enable register.
- FALL_EN_RESET, 8'h00, reset value of the falling-edge enable register.

Ports:
- clk_i  in  1  system clock; all state changes on the rising edge.
- res_i  in  1  reset; asynchronous, active-low.
- pins_i  in  8  asynchronous external inputs.
- stb_i  in  1  access strobe; one access per cycle while high.
- we_i  in  1  1 = write, 0 = read; sampled with stb_i.
- adr_i  in  2  register select; sampled with stb_i.
- dat_i  in  8  write data.
- dat_o  out  8  read data; valid while ack_o is high.
- ack_o  out  1  access acknowledge.
- irq_o  out  1  high while any event flag is set.

Behaviour:
- Reset (res_i low, asynchronous):
  - Synchronizer chain, prev register and events register reset to 0.
  - rise_en resets to RISE_EN_RESET; fall_en resets to FALL_EN_RESET.
  - dat_o = 0, ack_o = 0, irq_o = 0.
  - Priming counter resets to 0; primed = 0.
- Synchronizer:
  - pins_i passes through SYNC_STAGES flops; the last stage is s[7:0].
  - prev loads s every cycle.
- Priming:
  - After reset deassertion the counter increments each clock until it reaches SYNC_STAGES+1, then primed = 1 and the counter holds.
  - Until primed, no events are generated. Pins that are high at reset therefore never raise spurious rise events.
- Edge detection:
  - rise = s & ~prev & rise_en & {8{primed}}.
  - fall = ~s & prev & fall_en & {8{primed}}.
  - events <= (events & ~clr) | rise | fall.
  - clr = dat_i when a write to adr 1 is accepted, otherwise 0.
  - If a new edge and a clear hit the same bit in the same cycle, set wins.
- Latency: a pin transition captured at edge k sets its event flag at edge k+SYNC_STAGES. With the default of 2, the flag sets 2 edges after capture.
- irq_o = |events, taken combinationally from the registered flags.
- Register map:
  - adr 0 PINS: read-only, returns s. Writes are ignored but still acked.
  - adr 1 EVENTS: reads return flags; a write clears each bit where dat_i is 1 (write-1-to-clear).
  - adr 2 RISE_EN: read/write.
  - adr 3 FALL_EN: read/write.
- Handshake:
  - ack_o <= stb_i, registered; ack_o goes high the cycle after stb_i.
  - Back-to-back accesses give a continuous ack_o.
  - dat_o is registered with the ack and holds its last value when ack_o is low.
  - Write effects become visible in the cycle ack_o is high.
  - Read data reflects register state at the edge where stb_i is sampled.
- Clearing an enable bit does not clear an already-latched flag for that bit.
- Reset asserted mid-access: ack_o drops immediately and the access is lost.

Test Plan:
1. Reset with pins_i=8'hA5 held, release, wait 6 clocks -> irq_o=0; EVENTS reads 8'h00; PINS reads 8'hA5.
2. RISE_EN=8'h0F; pins_i 8'h00->8'hFF -> EVENTS=8'h0F exactly 2 edges after capture; irq_o=1.
3. FALL_EN=8'hF0, RISE_EN=0; pins_i 8'hFF->8'h00 -> EVENTS=8'hF0. Then write 8'h30 to EVENTS -> EVENTS=8'hC0, irq_o stays 1. Write 8'hC0 -> irq_o=0.
4. Rise event on bit 0 in the same cycle as a write of 8'h01 to EVENTS -> bit 0 remains 1.
5. Back-to-back, stb_i held 4 cycles: reads of adr 0,1,2,3 -> ack_o high for 4 consecutive cycles with correct dat_o each cycle. Write of 8'h55 to PINS is acked with no effect.
6. Assert res_i low mid-read -> ack_o=0 and irq_o=0 at once. Enables return to RISE_EN_RESET/FALL_EN_RESET.
